apb_spi_regs: RTL and testbench

APB slave register block that sits directly downstream of the APB master bus. It terminates PSEL/PENABLE/PWRITE transfers and exposes CTRL, STATUS, TXDATA and RXDATA registers. It buffers words in a TX FIFO toward the SPI engine and in an RX FIFO from the SPI engine. A TXDATA write to a full FIFO stalls the bus with PREADY low.

---
 rtl/apb_spi_regs_pkg.sv | 33 +++
 rtl/apb_spi_regs_sync_fifo.sv | 56 +++++
 rtl/apb_spi_regs.sv | 148 ++++++++++++++
 tb/tb_apb_spi_regs.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_spi_regs_pkg.sv
// Register map, field indices and CTRL layout shared by the apb_spi_regs block.
package apb_spi_regs_pkg;

    localparam logic [3:0] ADDR_CTRL   = 4'h0;
    localparam logic [3:0] ADDR_STATUS = 4'h4;
    localparam logic [3:0] ADDR_TXDATA = 4'h8;
    localparam logic [3:0] ADDR_RXDATA = 4'hC;

    localparam int CTRL_SPI_EN   = 0;
    localparam int CTRL_CPOL     = 1;
    localparam int CTRL_CPHA     = 2;
    localparam int CTRL_TX_FLUSH = 3;

    localparam int ST_TX_FULL  = 0;
    localparam int ST_TX_EMPTY = 1;
    localparam int ST_RX_FULL  = 2;
    localparam int ST_RX_EMPTY = 3;
    localparam int ST_RX_OVF   = 4;
    localparam int ST_RX_UNF   = 5;

    // Only spi_en/cpol/cpha and clk_div are stored; tx_flush is a strobe.
    localparam logic [15:0] CTRL_WMASK = 16'hFF07;

    typedef struct packed {
        logic [7:0] clk_div;
        logic [3:0] rsvd;
        logic       tx_flush;
        logic       cpha;
        logic       cpol;
        logic       spi_en;
    } ctrl_t;

endpackage

// File: rtl/apb_spi_regs_sync_fifo.sv
// Single-clock FIFO with flush; a push into a full FIFO is accepted only when
// a pop happens on the same edge, so pop-then-push never overflows.
module sync_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [DATA_W-1:0]        din,
    output logic [DATA_W-1:0]        dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic              do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/apb_spi_regs.sv
// APB register front-end for an SPI engine: CTRL/STATUS/TXDATA/RXDATA with TX and RX FIFOs.
// Optional PSLVERR error response when APB_SPI_REGS_PSLVERR_EN is defined.
module apb_spi_regs
    import apb_spi_regs_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
`ifdef APB_SPI_REGS_PSLVERR_EN
    output logic              PSLVERR,
`endif
    output logic [DATA_W-1:0] ctrl_o,
    output logic              tx_valid,
    output logic [DATA_W-1:0] tx_data,
    input  logic              tx_ready,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] rx_data
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    // Handshakes: an APB transfer completes on an edge with PSEL&PENABLE&PREADY;
    // a TX word transfers on an edge with tx_valid&tx_ready; rx_valid is a push
    // strobe with no backpressure (dropped words raise rx_ovf).
    logic              setup_ph, access_ph, done, wr_ok, rd_done, err;
    logic              mapped, sel_ctrl, sel_status, sel_tx, sel_rx;
    ctrl_t             ctrl_q;
    logic              rx_ovf_q, rx_unf_q, rd_empty_q;
    logic              tx_full, tx_empty, rx_full, rx_empty;
    logic              tx_push, tx_pop, tx_flush, rx_pop, rx_ovf_set, rx_unf_set;
    logic [CNT_W-1:0]  tx_count, rx_count;
    logic [DATA_W-1:0] rx_head, status_w, rd_mux;

    assign setup_ph  = PSEL & ~PENABLE;
    assign access_ph = PSEL & PENABLE;

    assign mapped     = (PADDR[ADDR_W-1:4] == '0);
    assign sel_ctrl   = mapped & (PADDR[3:0] == ADDR_CTRL);
    assign sel_status = mapped & (PADDR[3:0] == ADDR_STATUS);
    assign sel_tx     = mapped & (PADDR[3:0] == ADDR_TXDATA);
    assign sel_rx     = mapped & (PADDR[3:0] == ADDR_RXDATA);

    assign PREADY  = ~(access_ph & PWRITE & sel_tx & tx_full);
    assign done    = access_ph & PREADY;
    assign wr_ok   = done & PWRITE & ~err;
    assign rd_done = done & ~PWRITE;

`ifdef APB_SPI_REGS_PSLVERR_EN
    always_comb begin
        err = 1'b0;
        if (!(sel_ctrl | sel_status | sel_tx | sel_rx))
            err = 1'b1;
        else if (PWRITE & sel_status & ((|PWDATA[DATA_W-1:6]) | (|PWDATA[3:0])))
            err = 1'b1;
        else if (PWRITE & sel_rx)
            err = 1'b1;
        else if (~PWRITE & sel_tx)
            err = 1'b1;
        else if (~PWRITE & sel_rx & rd_empty_q)
            err = 1'b1;
    end
    assign PSLVERR = access_ph & err;
`else
    assign err = 1'b0;
`endif

    assign tx_push  = wr_ok & sel_tx;
    assign tx_flush = wr_ok & sel_ctrl & PWDATA[CTRL_TX_FLUSH];
    assign tx_valid = ctrl_q.spi_en & ~tx_empty;
    assign tx_pop   = tx_valid & tx_ready;
    assign ctrl_o   = DATA_W'(ctrl_q);

    // Emptiness is latched at the setup edge so the returned word and the pop agree
    // even if rx_valid fills an empty FIFO between setup and completion.
    assign rx_pop     = rd_done & sel_rx & ~rd_empty_q;
    assign rx_unf_set = rd_done & sel_rx & rd_empty_q;
    assign rx_ovf_set = rx_valid & rx_full & ~rx_pop;

    sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(PCLK), .rst(PRESET), .push(tx_push), .pop(tx_pop), .flush(tx_flush),
        .din(PWDATA), .dout(tx_data), .full(tx_full), .empty(tx_empty), .count(tx_count)
    );

    sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(PCLK), .rst(PRESET), .push(rx_valid), .pop(rx_pop), .flush(1'b0),
        .din(rx_data), .dout(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
    );

    always_comb begin
        status_w              = '0;
        status_w[ST_TX_FULL]  = tx_full;
        status_w[ST_TX_EMPTY] = tx_empty;
        status_w[ST_RX_FULL]  = rx_full;
        status_w[ST_RX_EMPTY] = rx_empty;
        status_w[ST_RX_OVF]   = rx_ovf_q;
        status_w[ST_RX_UNF]   = rx_unf_q;
    end

    always_comb begin
        rd_mux = '0;
        if (mapped) begin
            case (PADDR[3:0])
                ADDR_CTRL:   rd_mux = DATA_W'(ctrl_q);
                ADDR_STATUS: rd_mux = status_w;
                ADDR_RXDATA: rd_mux = rx_empty ? '0 : rx_head;
                default:     rd_mux = '0;
            endcase
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            ctrl_q     <= '0;
            rx_ovf_q   <= 1'b0;
            rx_unf_q   <= 1'b0;
            rd_empty_q <= 1'b1;
            PRDATA     <= '0;
        end else begin
            if (wr_ok & sel_ctrl) ctrl_q <= ctrl_t'(PWDATA[15:0] & CTRL_WMASK);

            if (rx_ovf_set)                                  rx_ovf_q <= 1'b1;
            else if (wr_ok & sel_status & PWDATA[ST_RX_OVF]) rx_ovf_q <= 1'b0;

            if (rx_unf_set)                                  rx_unf_q <= 1'b1;
            else if (wr_ok & sel_status & PWDATA[ST_RX_UNF]) rx_unf_q <= 1'b0;

            if (setup_ph & ~PWRITE) begin
                PRDATA     <= rd_mux;
                rd_empty_q <= rx_empty;
            end
        end
    end

    // FIFO occupancy never exceeds its depth.
    a_occupancy: assert property (@(posedge PCLK) disable iff (PRESET)
        (tx_count <= CNT_W'(FIFO_DEPTH)) && (rx_count <= CNT_W'(FIFO_DEPTH)));

endmodule

// File: tb/tb_apb_spi_regs.sv
// Scoreboard bench for apb_spi_regs: directed scenarios followed by a randomized op mix.
// Build with APB_SPI_REGS_PSLVERR_EN defined to also exercise PSLVERR.
`timescale 1ns/1ps
module tb_apb_spi_regs;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;

  logic              PCLK = 1'b0;
  logic              PRESET;
  logic [ADDR_W-1:0] PADDR;
  logic              PSEL, PENABLE, PWRITE, PREADY;
  logic [DATA_W-1:0] PWDATA, PRDATA;
  logic [DATA_W-1:0] ctrl_o, tx_data, rx_data;
  logic              tx_valid, tx_ready, rx_valid;
`ifdef APB_SPI_REGS_PSLVERR_EN
  logic              PSLVERR;
`endif

  apb_spi_regs #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
`ifdef APB_SPI_REGS_PSLVERR_EN
    .PSLVERR(PSLVERR),
`endif
    .ctrl_o(ctrl_o), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data)
  );

  // ---------------- clock / reset ----------------
  always #5 PCLK = ~PCLK;

  // ---------------- scoreboard and reference model ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [DATA_W-1:0] exp_q[$];     // expected PRDATA per read, in issue order
  logic [DATA_W-1:0] tx_exp[$];    // words accepted into TX, in order
  logic [DATA_W-1:0] rx_model[$];  // words held in RX, in order
  logic [DATA_W-1:0] m_ctrl;
  bit                m_ovf, m_unf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] m_status();
    return {10'b0, m_unf, m_ovf, rx_model.size() == 0, rx_model.size() == DEPTH,
            tx_exp.size() == 0, tx_exp.size() == DEPTH};
  endfunction

  function automatic logic [DATA_W-1:0] m_read_value(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] v = '0;
    if (a[ADDR_W-1:4] == 0) begin
      case (a[3:0])
        4'h0: v = m_ctrl;
        4'h4: v = m_status();
        4'hC: v = (rx_model.size() == 0) ? '0 : rx_model[0];
        default: v = '0;
      endcase
    end
    return v;
  endfunction

  function automatic bit m_err(input logic [ADDR_W-1:0] a, input bit wr, input logic [DATA_W-1:0] d);
    bit r = 1'b1;
    if (a[ADDR_W-1:4] == 0) begin
      case (a[3:0])
        4'h0: r = 1'b0;
        4'h4: r = wr && ((d & ~16'h0030) != 0);
        4'h8: r = !wr;
        4'hC: r = wr || (rx_model.size() == 0);
        default: r = 1'b1;
      endcase
    end
    return r;
  endfunction

  // ---------------- monitors ----------------
  always @(negedge PCLK) begin
    if (!PRESET && PSEL && PENABLE && !PWRITE && PREADY) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL rd_unexpected: got 0x%0h expected no read", PRDATA);
      end else check("prdata", PRDATA, exp_q.pop_front());
    end
  end

  always @(negedge PCLK) begin
    if (!PRESET && tx_valid && tx_ready) begin
      if (tx_exp.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL tx_unexpected: got 0x%0h expected no pop", tx_data);
      end else check("tx_data", tx_data, tx_exp.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apb_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input int exp_waits);
    int waits = 0;
    bit ok = 1'b0;
    bit e = 1'b0;
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge PCLK);
      if (PREADY) begin ok = 1'b1; break; end
      waits++;
    end
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL wr_timeout: got PREADY=0 for 50 cycles expected completion, addr 0x%0h", a);
    end else begin
      check("wr_waits", waits, exp_waits);
`ifdef APB_SPI_REGS_PSLVERR_EN
      e = m_err(a, 1'b1, d);
      check("wr_pslverr", PSLVERR, e);
`endif
      if (!e && a[ADDR_W-1:4] == 0) begin
        case (a[3:0])
          4'h0: begin m_ctrl = d & 16'hFF07; if (d[3]) tx_exp.delete(); end
          4'h4: begin if (d[4]) m_ovf = 1'b0; if (d[5]) m_unf = 1'b0; end
          4'h8: tx_exp.push_back(d);
          default: ;
        endcase
      end
    end
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic apb_read(input logic [ADDR_W-1:0] a, input bit with_rx, input logic [DATA_W-1:0] rxd);
    bit e;
    exp_q.push_back(m_read_value(a));
    e = m_err(a, 1'b0, '0);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    if (with_rx) begin rx_valid = 1'b1; rx_data = rxd; end
    @(negedge PCLK);
    check("rd_pready", PREADY, 1'b1);
`ifdef APB_SPI_REGS_PSLVERR_EN
    check("rd_pslverr", PSLVERR, e);
`endif
    if (a[ADDR_W-1:4] == 0 && a[3:0] == 4'hC) begin
      if (rx_model.size() == 0) m_unf = 1'b1;
      else void'(rx_model.pop_front());
    end
    if (with_rx) begin
      if (rx_model.size() < DEPTH) rx_model.push_back(rxd);
      else m_ovf = 1'b1;
    end
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; rx_valid = 1'b0;
  endtask

  task automatic rx_pulse(input logic [DATA_W-1:0] d);
    @(posedge PCLK); #1;
    rx_valid = 1'b1; rx_data = d;
    @(posedge PCLK); #1;
    rx_valid = 1'b0;
    if (rx_model.size() == DEPTH) m_ovf = 1'b1;
    else rx_model.push_back(d);
  endtask

  task automatic drain(input int k);
    @(posedge PCLK); #1;
    tx_ready = 1'b1;
    repeat (k) begin
      #2;
      check("tx_valid", tx_valid, (m_ctrl[0] && tx_exp.size() != 0));
      @(posedge PCLK); #1;
    end
    tx_ready = 1'b0;
  endtask

  task automatic model_reset();
    m_ctrl = '0; m_ovf = 1'b0; m_unf = 1'b0;
    tx_exp.delete(); rx_model.delete();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected end before 400us");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
    model_reset();
    repeat (3) @(posedge PCLK);
    #1;
    check("rst_prdata", PRDATA, 16'h0);
    check("rst_pready", PREADY, 1'b1);
    check("rst_ctrl_o", ctrl_o, 16'h0);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_data", tx_data, 16'h0);
`ifdef APB_SPI_REGS_PSLVERR_EN
    check("rst_pslverr", PSLVERR, 1'b0);
`endif
    PRESET = 1'b0;

    // CTRL round trip
    apb_write(16'h0000, 16'h0A07, 0);
    check("ctrl_o", ctrl_o, 16'h0A07);
    apb_read(16'h0000, 1'b0, '0);

    // fill TX with engine disabled, then stall a fifth write
    apb_write(16'h0000, 16'h0A06, 0);
    for (int i = 1; i <= 4; i++) apb_write(16'h0008, 16'(i * 16'h1111), 0);
    apb_read(16'h0004, 1'b0, '0);
    check("tx_valid_disabled", tx_valid, 1'b0);
    apb_write(16'h0000, 16'h0A07, 0);
    #2;
    check("tx_valid_enabled", tx_valid, 1'b1);
    check("tx_head", tx_data, 16'h1111);
    fork
      apb_write(16'h0008, 16'h5555, 2);
      begin
        repeat (3) @(negedge PCLK);
        check("stall_pready", PREADY, 1'b0);
        @(posedge PCLK); #1; tx_ready = 1'b1;
        @(posedge PCLK); #1; tx_ready = 1'b0;
      end
    join
    drain(6);
    check("tx_drained", tx_exp.size(), 0);
    check("tx_valid_empty", tx_valid, 1'b0);

    // RX overflow, underflow, W1C
    for (int i = 1; i <= 5; i++) rx_pulse(16'(16'hA0 + i));
    apb_read(16'h0004, 1'b0, '0);
    for (int i = 0; i < 5; i++) apb_read(16'h000C, 1'b0, '0);
    apb_read(16'h0004, 1'b0, '0);
    apb_write(16'h0004, 16'h0030, 0);
    apb_read(16'h0004, 1'b0, '0);

    // full RX: push coincident with pop must not overflow
    for (int i = 1; i <= 4; i++) rx_pulse(16'(16'hB0 + i));
    apb_read(16'h000C, 1'b1, 16'h00B5);
    apb_read(16'h0004, 1'b0, '0);
    for (int i = 0; i < 4; i++) apb_read(16'h000C, 1'b0, '0);

    // flush empties TX and reads back 0
    apb_write(16'h0000, 16'h0000, 0);
    apb_write(16'h0008, 16'h1234, 0);
    apb_write(16'h0008, 16'h5678, 0);
    apb_write(16'h0000, 16'h0008, 0);
    apb_read(16'h0000, 1'b0, '0);
    apb_read(16'h0004, 1'b0, '0);

`ifdef APB_SPI_REGS_PSLVERR_EN
    apb_read(16'h0010, 1'b0, '0);
    #2;
    check("pslverr_one_cycle", PSLVERR, 1'b0);
    rx_pulse(16'h00C1);
    apb_write(16'h000C, 16'hDEAD, 0);
    apb_read(16'h000C, 1'b0, '0);
    apb_read(16'h0004, 1'b0, '0);
`endif

    // reset during a stalled TXDATA access
    apb_write(16'h0000, 16'h3306, 0);
    for (int i = 0; i < 4; i++) apb_write(16'h0008, 16'($urandom), 0);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 16'h0008; PWDATA = 16'h7777;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #2;
    check("pre_rst_stall", PREADY, 1'b0);
    PRESET = 1'b1;
    #1;
    check("mid_rst_pready", PREADY, 1'b1);
    check("mid_rst_ctrl_o", ctrl_o, 16'h0);
    check("mid_rst_tx_valid", tx_valid, 1'b0);
    model_reset();
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    apb_read(16'h0004, 1'b0, '0);

    // randomized op mix
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 8))
        0: apb_write(16'h0000, 16'($urandom) & (($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'hFFF7), 0);
        1: if (tx_exp.size() < DEPTH) apb_write(16'h0008, 16'($urandom), 0);
           else apb_read(16'h0004, 1'b0, '0);
        2: apb_read(16'h0004, 1'b0, '0);
        3: apb_read(16'h000C, 1'b0, '0);
        4: apb_read(16'h0000, 1'b0, '0);
        5: rx_pulse(16'($urandom));
        6: apb_write(16'h0004, ($urandom_range(0, 1) == 1) ? 16'(16'h0010 << $urandom_range(0, 1)) : 16'($urandom), 0);
        7: begin
             a = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
             d = 16'($urandom);
             if ($urandom_range(0, 1) == 1) apb_read(a, 1'b0, '0);
             else if (!(a[ADDR_W-1:4] == 0 && a[3:0] == 4'h8 && tx_exp.size() == DEPTH)) apb_write(a, d, 0);
           end
        default: drain($urandom_range(1, 5));
      endcase
    end
    apb_read(16'h0004, 1'b0, '0);
    apb_read(16'h0000, 1'b0, '0);

    repeat (3) @(posedge PCLK);
    check("reads_all_seen", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
